etc_th_dispatch_ctrl: RTL
=========================

# etc_th_dispatch_ctrl

Block-level sequencer in front of the ETC2 T/H-mode base-colour unit. Accepts 64-bit ETC2 RGB blocks over a valid/ready handshake, classifies each block's mode (individual, differential, T, H, planar), drives the T/H unit with the correct request/mode/block sequence for T and H blocks, captures its four base colours, and presents one result per block downstream. Non-T/H blocks pass through with mode tagged and colours zeroed for the other decode units.

## Interface
Parameters:
- TIMEOUT_CYCLES, 8, max cycles in ISSUE before abort (used only with ETC_TH_TIMEOUT_EN); legal range 3..255

Ports:
- sclk  input  1  clock, all logic on rising edge
- rsrt  input  1  reset, synchronous, active-high
- in_valid  input  1  upstream block valid
- in_ready  output  1  block accepted on edge when in_valid && in_ready
- in_block  input  64  ETC2 RGB block, bit 63 = first bit of block
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_mode  output  3  0 individual, 1 differential, 2 T, 3 H, 4 planar (same codes as etc_param.vh)
- out_block  output  64  the accepted block, unchanged
- out_color0..out_color3  output  24 each  base colours from T/H unit; 0 for other modes
- out_err  output  1  T/H unit timed out for this block
- th_rtr  output  1  request to T/H unit
- th_mode  output  3  mode to T/H unit
- th_block  output  64  block to T/H unit
- th_color_rts  input  1  T/H unit result valid
- th_color0..th_color3  input  24 each  T/H unit base colours

## Operation
- States: IDLE, ISSUE, OUT. in_ready = (state == IDLE).
- Classification (combinational on in_block at accept, registered into out_mode):
  - bit 33 = 0 -> individual.
  - Else 6-bit signed sums R = {0,bits[63:59]} + sext(bits[58:56]), G = bits[55:51] + sext(bits[50:48]), B = bits[47:43] + sext(bits[42:40]); a sum is out of range if <0 or >31.
  - Priority: R out of range -> T; else G -> H; else B -> planar; else differential.
- IDLE: on accept, latch in_block into out_block/th_block, write out_mode/th_mode, clear out_err and colours. T or H -> ISSUE; otherwise -> OUT.
- ISSUE: th_rtr = 1 continuously. On edge with th_color_rts = 1, capture th_color0..3 into out_color0..3 -> OUT.
- OUT: out_valid = 1; all out_* held stable until out_ready; on edge with out_ready -> IDLE.
- th_rtr is 0 outside ISSUE; th_block/th_mode hold last latched value.
- th_color_rts outside ISSUE is ignored.
- in_valid outside IDLE is ignored (not accepted).

## Timing
- Reset values: state IDLE, in_ready 1 (after reset edge), out_valid 0, th_rtr 0, out_mode 0, th_mode 0, out_block 0, th_block 0, out_color0..3 0, out_err 0, watchdog counter 0.
- Reset asserted in any state: next edge forces IDLE; in-flight block discarded; th_rtr low the following cycle.
- Accept edge E0. Non-T/H: out_valid high in cycle after E0.
- T/H with the standard colour unit: th_rtr high after E0; unit registers at E1; th_color_rts high after E1; capture at E2; out_valid high after E2. th_rtr high for exactly 2 cycles.
- out_ready may already be high when out_valid rises; handoff takes one edge. No same-edge accept of a new block: throughput 2 cycles/block non-T/H, 4 cycles/block T/H with out_ready tied high.

## Configuration
- ETC_TH_TIMEOUT_EN defined: counter counts cycles in ISSUE; if it reaches TIMEOUT_CYCLES without th_color_rts, go to OUT with out_err = 1, out_color0..3 = 0, th_rtr dropped. th_color_rts on the same edge as expiry wins (normal capture, out_err 0).
- Not defined: no counter; ISSUE waits indefinitely; out_err is constant 0.

## Test plan
- Individual: in_block 64'h0 -> out_mode 0, out_valid one cycle after accept, colours 0, th_rtr never high.
- T: in_block 64'hF900_0002_0000_0000 (R = 31 + 1) -> out_mode 2, th_mode 2, th_rtr high 2 cycles, out_colorN = th_colorN sampled on the capture edge, out_valid after E2.
- H/planar/differential: 64'h00F9_0002_0000_0000 -> mode 3 via ISSUE; 64'h0000_F902_0000_0000 -> mode 4 bypass; 64'h0000_0002_0000_0000 -> mode 1; 64'h0400_0002_0000_0000 (R = 0 - 4) -> mode 2.
- Backpressure: out_ready low 5 cycles, in_valid high -> out_* stable, in_ready 0, no second accept; next block accepted one edge after out_ready handoff.
- Timeout (macro on, TIMEOUT_CYCLES 8): th_color_rts tied 0 on T block -> out_valid with out_err 1, colours 0, th_rtr low after 8 ISSUE cycles. Macro off: th_rtr stays 1, out_valid stays 0.
- Reset in ISSUE: rsrt one cycle -> IDLE, th_rtr 0, out_valid 0, in_ready 1; next block decodes correctly.

Source files
------------

// File: rtl/etc_th_dispatch_ctrl.sv
// etc_th_dispatch_ctrl
//   Block-level sequencer in front of the ETC2 T/H-mode base-colour unit.
//   Accepts 64-bit ETC2 RGB blocks, classifies the mode, runs T/H blocks
//   through the colour unit and presents one result per block downstream.
//   Non-T/H blocks bypass the unit with colours forced to zero.
//
// Ports:
//   sclk, rsrt                  clock (rising edge), synchronous active-high reset
//   in_valid/in_ready/in_block  upstream block handshake (bit 63 = first bit)
//   out_valid/out_ready         downstream result handshake
//   out_mode                    0 indiv, 1 diff, 2 T, 3 H, 4 planar
//   out_block                   accepted block, unchanged
//   out_color0..3               T/H base colours, 0 for other modes
//   out_err                     T/H unit timed out for this block
//   th_rtr/th_mode/th_block     request side of the T/H unit
//   th_color_rts/th_color0..3   result side of the T/H unit
//
// Configuration macro:
//   ETC_TH_TIMEOUT_EN  enables the ISSUE watchdog (TIMEOUT_CYCLES, 3..255).
//                      Undefined: ISSUE waits indefinitely, out_err is 0.

module etc_th_dispatch_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        sclk,
  input  logic        rsrt,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_mode,
  output logic [63:0] out_block,
  output logic [23:0] out_color0,
  output logic [23:0] out_color1,
  output logic [23:0] out_color2,
  output logic [23:0] out_color3,
  output logic        out_err,
  output logic        th_rtr,
  output logic [2:0]  th_mode,
  output logic [63:0] th_block,
  input  logic        th_color_rts,
  input  logic [23:0] th_color0,
  input  logic [23:0] th_color1,
  input  logic [23:0] th_color2,
  input  logic [23:0] th_color3
);

  localparam logic [2:0] MODE_IND    = 3'd0;
  localparam logic [2:0] MODE_DIFF   = 3'd1;
  localparam logic [2:0] MODE_T      = 3'd2;
  localparam logic [2:0] MODE_H      = 3'd3;
  localparam logic [2:0] MODE_PLANAR = 3'd4;

  if (TIMEOUT_CYCLES < 3 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("etc_th_dispatch_ctrl: TIMEOUT_CYCLES must be in 3..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [63:0] block_q, block_d;
  logic [23:0] color0_q, color0_d;
  logic [23:0] color1_q, color1_d;
  logic [23:0] color2_q, color2_d;
  logic [23:0] color3_q, color3_d;

`ifdef ETC_TH_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdog_q, wdog_d;
  logic       err_q, err_d;
`endif

  // Mode classification. Sums are 7 bits wide so both underflow (bit 6)
  // and overflow past 31 (bit 5) show up without wrapping.
  logic [6:0] sum_r, sum_g, sum_b;
  logic [2:0] cls_mode;

  always_comb begin
    sum_r = {2'b00, in_block[63:59]} + {{4{in_block[58]}}, in_block[58:56]};
    sum_g = {2'b00, in_block[55:51]} + {{4{in_block[50]}}, in_block[50:48]};
    sum_b = {2'b00, in_block[47:43]} + {{4{in_block[42]}}, in_block[42:40]};
    if (!in_block[33]) begin
      cls_mode = MODE_IND;
    end else if (|sum_r[6:5]) begin
      cls_mode = MODE_T;
    end else if (|sum_g[6:5]) begin
      cls_mode = MODE_H;
    end else if (|sum_b[6:5]) begin
      cls_mode = MODE_PLANAR;
    end else begin
      cls_mode = MODE_DIFF;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    block_d  = block_q;
    color0_d = color0_q;
    color1_d = color1_q;
    color2_d = color2_q;
    color3_d = color3_q;
`ifdef ETC_TH_TIMEOUT_EN
    wdog_d   = wdog_q;
    err_d    = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          block_d  = in_block;
          mode_d   = cls_mode;
          color0_d = '0;
          color1_d = '0;
          color2_d = '0;
          color3_d = '0;
`ifdef ETC_TH_TIMEOUT_EN
          wdog_d   = '0;
          err_d    = 1'b0;
`endif
          if (cls_mode == MODE_T || cls_mode == MODE_H) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_OUT;
          end
        end
      end

      ST_ISSUE: begin
        // A result arriving on the expiry edge still wins over the timeout.
        if (th_color_rts) begin
          color0_d = th_color0;
          color1_d = th_color1;
          color2_d = th_color2;
          color3_d = th_color3;
          state_d  = ST_OUT;
        end
`ifdef ETC_TH_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = ST_OUT;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end

      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rsrt) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      block_q  <= '0;
      color0_q <= '0;
      color1_q <= '0;
      color2_q <= '0;
      color3_q <= '0;
`ifdef ETC_TH_TIMEOUT_EN
      wdog_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      block_q  <= block_d;
      color0_q <= color0_d;
      color1_q <= color1_d;
      color2_q <= color2_d;
      color3_q <= color3_d;
`ifdef ETC_TH_TIMEOUT_EN
      wdog_q   <= wdog_d;
      err_q    <= err_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_OUT);
  assign th_rtr     = (state_q == ST_ISSUE);
  assign out_mode   = mode_q;
  assign th_mode    = mode_q;
  assign out_block  = block_q;
  assign th_block   = block_q;
  assign out_color0 = color0_q;
  assign out_color1 = color1_q;
  assign out_color2 = color2_q;
  assign out_color3 = color3_q;
`ifdef ETC_TH_TIMEOUT_EN
  assign out_err    = err_q;
`else
  assign out_err    = 1'b0;
`endif

endmodule
